// File: rtl/sum_of_squares.sv
// sum_of_squares: iterative a*a + b*b for two signed W-bit components.
// A single shift-add datapath consumes one multiplier bit per clock. It squares
// |a| for W cycles and then |b| for W cycles, both into one 2W-bit accumulator.
// The sum output feeds the square-root stage of a vector-magnitude path. It is
// held stable between results, and rdy is a registered single-cycle pulse.
module sum_of_squares #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active-low
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             rdy,
    output logic [2*W-1:0]   sum
);

    localparam int SW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_A = 2'd1,
        SQ_B = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mag_a_q, mag_a_d;
    logic [W-1:0]    mag_b_q, mag_b_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            rdy_q, rdy_d;

    logic            accept;
    logic            last_bit;
    logic            squaring;
    logic [W-1:0]    mag_sel;
    logic [SW-1:0]   addend;
    logic [SW-1:0]   acc_sum;
    logic [SW-1:0]   shifted [W];

    // Two's-complement magnitude. The most negative input maps to 2^(W-1).
    // That value still fits the W-bit unsigned result, so no extra bit is needed.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
        return v[W-1] ? ((~v) + W'(1)) : v;
    endfunction

    // A new request is honoured only while not computing.
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (cnt_q == CW'(W - 1));
    assign squaring = (state_q == SQ_A) || (state_q == SQ_B);

    // The operand being squared is selected by phase. Both phases share one
    // accumulator, so the second square lands on top of the first.
    assign mag_sel = (state_q == SQ_B) ? mag_b_q : mag_a_q;

    // Table of the operand pre-shifted by every bit position. The counter picks
    // one entry per cycle, which keeps the adder input a simple mux.
    for (genvar gi = 0; gi < W; gi++) begin : g_shift
        assign shifted[gi] = {{W{1'b0}}, mag_sel} << gi;
    end

    assign addend  = mag_sel[cnt_q] ? shifted[cnt_q] : '0;
    assign acc_sum = acc_q + addend;

    // Next-state logic: two W-cycle squaring phases, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)    state_d = SQ_A;
            SQ_A: if (last_bit) state_d = SQ_B;
            SQ_B: if (last_bit) state_d = DONE;
            DONE: state_d = start ? SQ_A : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch magnitudes on accept, then shift-add one bit per cycle.
    always_comb begin
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        if (accept) begin
            mag_a_d = magnitude(a);
            mag_b_d = magnitude(b);
            acc_d   = '0;
            cnt_d   = '0;
        end else if (squaring) begin
            acc_d = acc_sum;
            cnt_d = last_bit ? '0 : (cnt_q + CW'(1));
            // The result is published only on the DONE-entry edge, so sum never
            // shows partial accumulations.
            if ((state_q == SQ_B) && last_bit) begin
                sum_d = acc_sum;
            end
        end
    end

    // Output decode from the next state. Registering it gives a glitch-free busy
    // and a rdy pulse that can never stretch across two cycles.
    always_comb begin
        busy_d = (state_d == SQ_A) || (state_d == SQ_B);
        rdy_d  = (state_d == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers. All of them clear immediately on reset,
    // which aborts any computation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    assign busy = busy_q;
    assign rdy  = rdy_q;
    assign sum  = sum_q;

endmodule

// File: tb/tb_sum_of_squares.sv
// Directed testbench for sum_of_squares.
// A cycle-level reference model checks busy, rdy and sum on every falling edge.
// Hand-computed literals pin both the DUT and the model at each result.
module tb_sum_of_squares;

    localparam int W  = 16;
    localparam int SW = 2 * W;
    localparam int LAT = 2 * W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          rdy;
    logic [SW-1:0] sum;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    sum_of_squares #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .rdy   (rdy),
        .sum   (sum)
    );

    always #5 clk = ~clk;

    // Reference model: a request taken while not computing yields a*a+b*b after
    // 2W busy cycles. The following cycle is the single rdy cycle.
    int            m_left = 0;
    logic          m_busy = 1'b0;
    logic          m_rdy  = 1'b0;
    logic [SW-1:0] m_sum  = '0;
    logic [SW-1:0] m_pend = '0;

    function automatic longint sq(input logic [W-1:0] v);
        longint s;
        s = longint'($signed(v));
        return s * s;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_sum  <= '0;
            m_pend <= '0;
        end else if (m_left == 0) begin
            m_rdy <= 1'b0;
            if (start) begin
                m_left <= 2 * W;
                m_pend <= SW'(sq(a) + sq(b));
                m_busy <= 1'b1;
            end else begin
                m_busy <= 1'b0;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_sum  <= m_pend;
                m_rdy  <= 1'b1;
                m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", longint'(busy), longint'(m_busy));
            check("cyc_rdy",  longint'(rdy),  longint'(m_rdy));
            check("cyc_sum",  longint'(sum),  longint'(m_sum));
        end
    end

    // One request. An optional extra start pulse with a=100 is raised at
    // cycle inj. That pulse falls while busy and must be ignored.
    task automatic run(input int av, input int bv, input longint exp, input int inj, input string tag);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        a = av[W-1:0];
        b = bv[W-1:0];
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!rdy && cyc < 100) begin
            if (cyc == inj) begin
                start = 1'b1;
                a = 16'd100;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_sum"}, longint'(sum), exp);
        check({tag, "_model"}, longint'(m_sum), exp);
        check({tag, "_busy_at_rdy"}, longint'(busy), 0);
        $display("txn %s a=%0d b=%0d sum=%0d latency=%0d", tag, av, bv, sum, cyc);
    endtask

    task automatic expect_no_rdy(input int cycles, input string tag);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (rdy) seen++;
        end
        check({tag, "_no_rdy"}, seen, 0);
    endtask

    initial begin
        int cyc;

        // Initial reset held for 3 cycles.
        #1 reset = 1'b0;
        #1;
        check("reset_busy", longint'(busy), 0);
        check("reset_rdy",  longint'(rdy),  0);
        check("reset_sum",  longint'(sum),  0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        run(3, 4, 25, -1, "basic");
        run(-32768, -32768, 64'h8000_0000, -1, "min_min");
        run(32767, -1, 1073676290, -1, "max_m1");
        run(0, 0, 0, -1, "zero");
        run(0, -7, 49, -1, "zero_m7");
        run(5, 12, 169, 10, "ignored_start");
        expect_no_rdy(40, "ignored_start");

        // Back-to-back: start held high. The next operands are presented in the rdy cycle.
        @(negedge clk);
        start = 1'b1;
        a = 16'd6;
        b = 16'd8;
        @(negedge clk);
        cyc = 1;
        while (!rdy && cyc < 100) begin @(negedge clk); cyc++; end
        check("b2b_first_latency", cyc, LAT);
        check("b2b_first_sum", longint'(sum), 100);
        $display("txn b2b_first a=6 b=8 sum=%0d latency=%0d", sum, cyc);
        a = 16'd1;
        b = 16'd1;
        @(negedge clk);
        cyc = 1;
        while (!rdy && cyc < 100) begin
            if (cyc == 16) check("b2b_hold_sum", longint'(sum), 100);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("b2b_second_latency", cyc, LAT);
        check("b2b_second_sum", longint'(sum), 2);
        check("b2b_second_model", longint'(m_sum), 2);
        $display("txn b2b_second a=1 b=1 sum=%0d latency=%0d", sum, cyc);

        // Reset mid-operation, applied between clock edges.
        @(negedge clk);
        start = 1'b1;
        a = 16'd9;
        b = 16'd9;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 15) begin @(negedge clk); cyc++; end
        check("mid_busy_before", longint'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_busy", longint'(busy), 0);
        check("mid_reset_rdy",  longint'(rdy),  0);
        check("mid_reset_sum",  longint'(sum),  0);
        $display("txn mid_reset busy=%0d rdy=%0d sum=%0d", busy, rdy, sum);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        expect_no_rdy(40, "after_reset");
        run(2, 2, 8, -1, "post_reset");

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
